// File: rtl/fp_mult_pkg.sv
// Shared definitions for the floating-point multiplier/divider front ends:
// control state encoding, exponent bias and significand product width.
package fp_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bias of an IEEE-style biased exponent field of the given width.
   function automatic int bias_f(input int exp_width);
      return (32'sd1 <<< (exp_width - 32'sd1)) - 32'sd1;
   endfunction

   // Width of the exact product of two significands including the hidden bit.
   function automatic int prod_width_f(input int mantissa_width);
      return 32'sd2 * (mantissa_width + 32'sd1);
   endfunction

endpackage

// File: rtl/fp_significand_multiplier_if.sv
// Operand/result handshake bundle of fp_significand_multiplier; the block
// itself attaches through the slave modport, the operand source through master.
interface fp_significand_multiplier_if #(
   parameter int EXP_WIDTH      = 8,
   parameter int MANTISSA_WIDTH = 23
);

   logic                              start_in;
   logic                              ready_out;
   logic                              a_sign_in;
   logic                              b_sign_in;
   logic [EXP_WIDTH-1:0]              a_exp_in;
   logic [EXP_WIDTH-1:0]              b_exp_in;
   logic [MANTISSA_WIDTH-1:0]         a_man_in;
   logic [MANTISSA_WIDTH-1:0]         b_man_in;
   logic                              sign_out;
   logic [EXP_WIDTH-1:0]              expoent_out;
   logic [2*(MANTISSA_WIDTH+1)-1:0]   result_out;
   logic                              carry_out;
   logic                              underflow_out;
   logic                              valid_out;
   logic                              ready_in;

   modport master (
      output start_in, a_sign_in, b_sign_in, a_exp_in, b_exp_in,
             a_man_in, b_man_in, ready_in,
      input  ready_out, sign_out, expoent_out, result_out, carry_out,
             underflow_out, valid_out
   );

   modport slave (
      input  start_in, a_sign_in, b_sign_in, a_exp_in, b_exp_in,
             a_man_in, b_man_in, ready_in,
      output ready_out, sign_out, expoent_out, result_out, carry_out,
             underflow_out, valid_out
   );

endinterface

// File: rtl/fp_significand_multiplier_exp_bias_adder.sv
// Combinational biased-exponent sum a + b - BIAS with overflow/underflow
// classification; shared between the multiplier and divider front ends.
module exp_bias_adder
   import fp_mult_pkg::*;
#(
   parameter int EXP_WIDTH = 8
) (
   input  logic [EXP_WIDTH-1:0] a_exp,
   input  logic [EXP_WIDTH-1:0] b_exp,
   output logic [EXP_WIDTH-1:0] expoent,
   output logic                 carry,
   output logic                 underflow
);

   localparam int SUM_WIDTH = EXP_WIDTH + 2;
   localparam logic [SUM_WIDTH-1:0] BIAS_EXT = SUM_WIDTH'(bias_f(EXP_WIDTH));

   logic [SUM_WIDTH-1:0] sum_s;

   // Two guard bits: bit EXP_WIDTH flags overflow, the top bit is the sign of S.
   always_comb begin
      sum_s     = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_EXT;
      underflow = sum_s[SUM_WIDTH-1];
      carry     = ~sum_s[SUM_WIDTH-1] & sum_s[EXP_WIDTH];
      expoent   = sum_s[EXP_WIDTH-1:0];
   end

endmodule

// File: rtl/fp_significand_multiplier.sv
// Sequential significand multiplier (one multiplier bit per cycle) with
// biased exponent sum. Optional zero-operand shortcut: FP_SIG_MULT_EARLY_EXIT_EN.
module fp_significand_multiplier
   import fp_mult_pkg::*;
#(
   parameter int EXP_WIDTH      = 8,
   parameter int MANTISSA_WIDTH = 23
) (
   input  logic                        clk_in,
   input  logic                        reset_n_in,
   fp_significand_multiplier_if.slave  bus
);

   localparam int SIG_WIDTH  = MANTISSA_WIDTH + 1;
   localparam int PROD_WIDTH = prod_width_f(MANTISSA_WIDTH);
   localparam int CNT_WIDTH  = $clog2(SIG_WIDTH + 1);
   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(SIG_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

   state_t                  state_r;
   state_t                  state_s;
   logic                    ready_s;
   logic                    valid_s;
   logic                    last_s;
   logic                    skip_s;

   logic [SIG_WIDTH-1:0]    a_sig_in_s;
   logic [SIG_WIDTH-1:0]    b_sig_in_s;
   logic [SIG_WIDTH-1:0]    a_sig_r;
   logic [PROD_WIDTH-1:0]   acc_r;
   logic [PROD_WIDTH-1:0]   acc_next_s;
   logic [SIG_WIDTH:0]      partial_s;
   logic [CNT_WIDTH-1:0]    cnt_r;
   logic [EXP_WIDTH-1:0]    a_exp_r;
   logic [EXP_WIDTH-1:0]    b_exp_r;
   logic                    sign_pend_r;

   logic [EXP_WIDTH-1:0]    expoent_s;
   logic                    carry_s;
   logic                    underflow_s;

   logic                    sign_r;
   logic [EXP_WIDTH-1:0]    expoent_r;
   logic [PROD_WIDTH-1:0]   result_r;
   logic                    carry_r;
   logic                    underflow_r;

   // Hidden bit is 0 only for a zero (denormal) exponent field.
   assign a_sig_in_s = {|bus.a_exp_in, bus.a_man_in};
   assign b_sig_in_s = {|bus.b_exp_in, bus.b_man_in};

`ifdef FP_SIG_MULT_EARLY_EXIT_EN
   logic zero_r;

   // Remembers at accept time whether either significand is zero.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         zero_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && bus.start_in) begin
         zero_r <= ~|a_sig_in_s | ~|b_sig_in_s;
      end
   end

   assign skip_s = zero_r;
`else
   assign skip_s = 1'b0;
`endif

   assign last_s = (state_r == ST_MULT) && ((cnt_r == LAST_BIT) || skip_s);

   exp_bias_adder #(
      .EXP_WIDTH (EXP_WIDTH)
   ) u_exp_bias_adder (
      .a_exp     (a_exp_r),
      .b_exp     (b_exp_r),
      .expoent   (expoent_s),
      .carry     (carry_s),
      .underflow (underflow_s)
   );

   // Low half of acc_r starts as B and is shifted out LSB first; A is added into the high half.
   always_comb begin
      if (acc_r[0]) begin
         partial_s = {1'b0, acc_r[PROD_WIDTH-1:SIG_WIDTH]} + {1'b0, a_sig_r};
      end else begin
         partial_s = {1'b0, acc_r[PROD_WIDTH-1:SIG_WIDTH]};
      end
      acc_next_s = {partial_s, acc_r[SIG_WIDTH-1:1]};
   end

   // Control state register.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start_in) begin
               state_s = ST_MULT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MULT: begin
            if (last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_MULT;
            end
         end
         ST_DONE: begin
            if (bus.ready_in) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      ready_s = 1'b0;
      valid_s = 1'b0;
      case (state_r)
         ST_IDLE: ready_s = 1'b1;
         ST_DONE: valid_s = 1'b1;
         default: begin
            ready_s = 1'b0;
            valid_s = 1'b0;
         end
      endcase
   end

   // Operand capture, shift-add iteration and result registers (updated only on completion).
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         a_sig_r     <= '0;
         acc_r       <= '0;
         cnt_r       <= '0;
         a_exp_r     <= '0;
         b_exp_r     <= '0;
         sign_pend_r <= 1'b0;
         sign_r      <= 1'b0;
         expoent_r   <= '0;
         result_r    <= '0;
         carry_r     <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start_in) begin
                  a_sig_r     <= a_sig_in_s;
                  acc_r       <= {{SIG_WIDTH{1'b0}}, b_sig_in_s};
                  cnt_r       <= '0;
                  a_exp_r     <= bus.a_exp_in;
                  b_exp_r     <= bus.b_exp_in;
                  sign_pend_r <= bus.a_sign_in ^ bus.b_sign_in;
               end
            end
            ST_MULT: begin
               acc_r <= acc_next_s;
               cnt_r <= cnt_r + CNT_ONE;
               if (last_s) begin
                  sign_r      <= sign_pend_r;
                  expoent_r   <= expoent_s;
                  carry_r     <= carry_s;
                  underflow_r <= underflow_s;
                  result_r    <= skip_s ? '0 : acc_next_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready_out     = ready_s;
   assign bus.valid_out     = valid_s;
   assign bus.sign_out      = sign_r;
   assign bus.expoent_out   = expoent_r;
   assign bus.result_out    = result_r;
   assign bus.carry_out     = carry_r;
   assign bus.underflow_out = underflow_r;

endmodule

// File: tb/tb_fp_significand_multiplier.sv
// Self-checking bench for fp_significand_multiplier: directed vector table,
// randomized operations against an arithmetic model, back-pressure and reset cases.
module tb_fp_significand_multiplier;

   localparam int EW = 8;
   localparam int MW = 23;
   localparam int PW = 2 * (MW + 1);
`ifdef FP_SIG_MULT_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic          a_sign;
      logic [EW-1:0] a_exp;
      logic [MW-1:0] a_man;
      logic          b_sign;
      logic [EW-1:0] b_exp;
      logic [MW-1:0] b_man;
      logic [PW-1:0] result;
      logic [EW-1:0] expo;
      logic          carry;
      logic          uf;
      logic          sign;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fp_significand_multiplier_if #(.EXP_WIDTH(EW), .MANTISSA_WIDTH(MW)) bus ();

   fp_significand_multiplier #(.EXP_WIDTH(EW), .MANTISSA_WIDTH(MW)) dut (
      .clk_in     (clk),
      .reset_n_in (rst_n),
      .bus        (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic as, input logic [EW-1:0] ae, input logic [MW-1:0] am,
                               input logic bs, input logic [EW-1:0] be, input logic [MW-1:0] bm,
                               input logic [PW-1:0] res, input logic [EW-1:0] ex,
                               input logic c, input logic u, input logic s);
      vec_t v;
      v.a_sign = as; v.a_exp = ae; v.a_man = am;
      v.b_sign = bs; v.b_exp = be; v.b_man = bm;
      v.result = res; v.expo = ex; v.carry = c; v.uf = u; v.sign = s;
      return v;
   endfunction

   // Arithmetic reference: real product of significands and signed exponent sum.
   function automatic vec_t model(input vec_t v);
      vec_t            r;
      longint unsigned sa;
      longint unsigned sb;
      int              s;
      r  = v;
      sa = {v.a_exp != 8'd0, v.a_man};
      sb = {v.b_exp != 8'd0, v.b_man};
      r.result = PW'(sa * sb);
      s        = int'(v.a_exp) + int'(v.b_exp) - ((1 << (EW - 1)) - 1);
      r.carry  = (s >= (1 << EW));
      r.uf     = (s < 0);
      r.expo   = EW'(s);
      r.sign   = v.a_sign ^ v.b_sign;
      return r;
   endfunction

   function automatic int exp_latency(input vec_t v);
      if (EARLY && (((v.a_exp == 8'd0) && (v.a_man == 23'd0)) ||
                    ((v.b_exp == 8'd0) && (v.b_man == 23'd0))))
         return 1;
      return MW + 1;
   endfunction

   task automatic drive(input vec_t v);
      bus.a_sign_in = v.a_sign; bus.a_exp_in = v.a_exp; bus.a_man_in = v.a_man;
      bus.b_sign_in = v.b_sign; bus.b_exp_in = v.b_exp; bus.b_man_in = v.b_man;
   endtask

   task automatic scramble();
      bus.a_sign_in = 1'($urandom); bus.a_exp_in = EW'($urandom); bus.a_man_in = MW'($urandom);
      bus.b_sign_in = 1'($urandom); bus.b_exp_in = EW'($urandom); bus.b_man_in = MW'($urandom);
   endtask

   task automatic check_out(input vec_t v, input string tag);
      chk({tag, "_result"},  64'(bus.result_out),    64'(v.result));
      chk({tag, "_expoent"}, 64'(bus.expoent_out),   64'(v.expo));
      chk({tag, "_carry"},   64'(bus.carry_out),     64'(v.carry));
      chk({tag, "_uflow"},   64'(bus.underflow_out), 64'(v.uf));
      chk({tag, "_sign"},    64'(bus.sign_out),      64'(v.sign));
   endtask

   // Accepts one operation, waits (bounded) for valid and checks latency and outputs.
   task automatic start_and_wait(input vec_t v, input string tag);
      int n;
      n = 0;
      while (!bus.ready_out && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_ready"}, 64'(bus.ready_out), 64'd1);
      drive(v);
      bus.start_in = 1'b1;
      @(posedge clk); #1;
      bus.start_in = 1'b0;
      scramble();
      n = 0;
      while (!bus.valid_out && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_latency(v)));
      check_out(v, tag);
   endtask

   task automatic run_op(input vec_t v, input string tag);
      start_and_wait(v, tag);
      @(posedge clk); #1;
      chk({tag, "_consumed_valid"}, 64'(bus.valid_out), 64'd0);
      chk({tag, "_consumed_ready"}, 64'(bus.ready_out), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"},   64'(bus.ready_out),     64'd1);
      chk({tag, "_valid"},   64'(bus.valid_out),     64'd0);
      chk({tag, "_result"},  64'(bus.result_out),    64'd0);
      chk({tag, "_expoent"}, 64'(bus.expoent_out),   64'd0);
      chk({tag, "_carry"},   64'(bus.carry_out),     64'd0);
      chk({tag, "_uflow"},   64'(bus.underflow_out), 64'd0);
      chk({tag, "_sign"},    64'(bus.sign_out),      64'd0);
   endtask

   initial begin
      vec_t tbl[8];
      vec_t v;

      rst_n        = 1'b0;
      bus.start_in = 1'b0;
      bus.ready_in = 1'b1;
      scramble();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      tbl[0] = mk(1'b0, 8'd127, 23'h400000, 1'b0, 8'd128, 23'h000000, 48'h600000000000, 8'd128, 1'b0, 1'b0, 1'b0);
      tbl[1] = mk(1'b1, 8'd127, 23'h7FFFFF, 1'b1, 8'd127, 23'h7FFFFF, 48'hFFFFFE000001, 8'd127, 1'b0, 1'b0, 1'b0);
      tbl[2] = mk(1'b1, 8'd254, 23'h000000, 1'b0, 8'd254, 23'h000000, 48'h400000000000, 8'd125, 1'b1, 1'b0, 1'b1);
      tbl[3] = mk(1'b0, 8'd1,   23'h000000, 1'b1, 8'd1,   23'h000000, 48'h400000000000, 8'd131, 1'b0, 1'b1, 1'b1);
      tbl[4] = mk(1'b0, 8'd0,   23'h000000, 1'b0, 8'd127, 23'h123456, 48'h000000000000, 8'd0,   1'b0, 1'b0, 1'b0);
      tbl[5] = mk(1'b0, 8'd127, 23'h000000, 1'b1, 8'd0,   23'h000005, 48'h000002800000, 8'd0,   1'b0, 1'b0, 1'b1);
      tbl[6] = mk(1'b0, 8'd255, 23'h000000, 1'b0, 8'd255, 23'h000000, 48'h400000000000, 8'd127, 1'b1, 1'b0, 1'b0);
      tbl[7] = mk(1'b0, 8'd0,   23'h000000, 1'b0, 8'd126, 23'h000000, 48'h000000000000, 8'd255, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i], $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 20; i++) begin
         v.a_sign = 1'($urandom); v.a_exp = EW'($urandom); v.a_man = MW'($urandom);
         v.b_sign = 1'($urandom); v.b_exp = EW'($urandom); v.b_man = MW'($urandom);
         v = model(v);
         run_op(v, $sformatf("rnd%0d", i));
      end

      // Back-pressure: result held in DONE while start_in pulses are ignored.
      bus.ready_in = 1'b0;
      start_and_wait(tbl[1], "bp");
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_hold%0d_valid", k), 64'(bus.valid_out), 64'd1);
         chk($sformatf("bp_hold%0d_ready", k), 64'(bus.ready_out), 64'd0);
         check_out(tbl[1], $sformatf("bp_hold%0d", k));
         drive(tbl[2]);
         bus.start_in = 1'b1;
         @(posedge clk); #1;
      end
      bus.start_in = 1'b0;
      chk("bp_still_valid", 64'(bus.valid_out), 64'd1);
      check_out(tbl[1], "bp_after_pulses");
      bus.ready_in = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 64'(bus.valid_out), 64'd0);
      chk("bp_release_ready", 64'(bus.ready_out), 64'd1);
      check_out(tbl[1], "bp_idle_hold");

      // Asynchronous reset in the middle of a multiplication.
      drive(tbl[0]);
      bus.start_in = 1'b1;
      @(posedge clk); #1;
      bus.start_in = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("mid_mult_busy", 64'(bus.ready_out), 64'd0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(tbl[1], "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
